// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-access controller.
// Holds the FSM encoding, command-byte layout and the default idle byte.
package spi_pkg;

    localparam int         ADDR_W        = 7;
    localparam int         CMD_RD_BIT    = 7;
    localparam logic [7:0] IDLE_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WDATA   = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RDATA   = 3'd4
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// N-flop synchronizer with an all-ones level output or a rising-edge output.
// Latency: STAGES cycles to the level; the rise output is combinational on the synced level.
module sync_edge_det #(
    parameter int STAGES  = 3,
    parameter bit RST_VAL = 1'b0,
    parameter bit RISE    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_ev
);

    logic [STAGES-1:0] r_sync;
    logic              r_lvl_d;
    logic              w_lvl;

    // Level requires every stage high, so short glitches never reach it.
    assign w_lvl = &r_sync;
    assign o_ev  = RISE ? (w_lvl & ~r_lvl_d) : w_lvl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= {STAGES{RST_VAL}};
            r_lvl_d <= RST_VAL;
        end else begin
            r_sync[0] <= i_din;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_lvl_d <= w_lvl;
        end
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Turns the spi_slave byte stream into framed register reads/writes with auto-increment.
// Write strobe 2 cycles after rec_flag rises; read data on send_data 4 cycles after; NCS-high aborts.
module spi_reg_ctrl
    import spi_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEF,
    parameter bit         AUTO_INC  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ncs,
    input  logic              rec_flag,
    input  logic [7:0]        rec_data,
    output logic [7:0]        send_data,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    input  logic [7:0]        reg_rdata,
    output logic              frame_done,
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_ncs_high;
    logic              w_byte_ev;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [7:0]        r_send_data;
    logic [ADDR_W-1:0] r_reg_addr;
    logic [7:0]        r_reg_wdata;
    logic              r_wr_en;
    logic              r_rd_en;
    logic              r_frame_done;
    logic              r_busy;
    logic              w_wr_en_nxt;
    logic              w_rd_en_nxt;
    logic [ADDR_W-1:0] w_reg_addr_nxt;
    logic [7:0]        w_wdata_nxt;

    sync_edge_det #(.STAGES(3), .RST_VAL(1'b1), .RISE(1'b0)) u_ncs_sync (
        .clk   (clk),
        .rst   (rst),
        .i_din (ncs),
        .o_ev  (w_ncs_high)
    );

    sync_edge_det #(.STAGES(1), .RST_VAL(1'b0), .RISE(1'b1)) u_rec_edge (
        .clk   (clk),
        .rst   (rst),
        .i_din (rec_flag),
        .o_ev  (w_byte_ev)
    );

    assign w_addr_inc = r_addr + ADDR_W'(AUTO_INC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_ncs_high) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (w_byte_ev) w_state_nxt = rec_data[CMD_RD_BIT] ? ST_RD_REQ : ST_WDATA;
                ST_WDATA:   w_state_nxt = ST_WDATA;
                ST_RD_REQ:  w_state_nxt = ST_RD_WAIT;
                ST_RD_WAIT: w_state_nxt = ST_RDATA;
                ST_RDATA:   if (w_byte_ev) w_state_nxt = ST_RD_REQ;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Read strobe is registered on entry to RD_REQ so that reg_rdata lands in RD_WAIT.
    always_comb begin
        w_wr_en_nxt    = 1'b0;
        w_rd_en_nxt    = 1'b0;
        w_reg_addr_nxt = r_reg_addr;
        w_wdata_nxt    = r_reg_wdata;
        if (!w_ncs_high) begin
            if (r_state == ST_WDATA && w_byte_ev) begin
                w_wr_en_nxt    = 1'b1;
                w_reg_addr_nxt = r_addr;
                w_wdata_nxt    = rec_data;
            end
            if (w_state_nxt == ST_RD_REQ) begin
                w_rd_en_nxt    = 1'b1;
                w_reg_addr_nxt = (r_state == ST_IDLE) ? rec_data[ADDR_W-1:0] : r_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_send_data  <= IDLE_BYTE;
            r_reg_addr   <= '0;
            r_reg_wdata  <= '0;
            r_wr_en      <= 1'b0;
            r_rd_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_reg_addr   <= w_reg_addr_nxt;
            r_reg_wdata  <= w_wdata_nxt;
            r_wr_en      <= w_wr_en_nxt;
            r_rd_en      <= w_rd_en_nxt;
            r_frame_done <= w_ncs_high & r_busy;
            if (w_ncs_high) begin
                r_send_data <= IDLE_BYTE;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_byte_ev) begin
                            r_addr <= rec_data[ADDR_W-1:0];
                            r_busy <= 1'b1;
                        end
                    end
                    ST_WDATA:   if (w_byte_ev) r_addr <= w_addr_inc;
                    ST_RD_WAIT: begin
                        r_send_data <= reg_rdata;
                        r_addr      <= w_addr_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign send_data  = r_send_data;
    assign reg_addr   = r_reg_addr;
    assign reg_wdata  = r_reg_wdata;
    assign reg_wr_en  = r_wr_en;
    assign reg_rd_en  = r_rd_en;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;

endmodule
